alu_scheduler: RTL and testbench

Sequencer and arbiter that shares one instance of the combinational `alu` between two requesters (port 0: execute stage, port 1: load/store address generation). It accepts one operation at a time via valid/ready handshakes, registers operands and result, and returns the result to the owning requester with its own valid/ready handshake. Arbitration between simultaneous requests is round-robin.

---
 rtl/alu_scheduler.sv | 168 ++++++++++++++++
 tb/tb_alu_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// ============================================================================
//  Module      : alu_scheduler (with internal combinational alu)
//  Description : Round-robin sequencer sharing one ALU between two requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] value1,
    input  logic [SIZE-1:0] value2,
    input  logic [2:0]      func_type,
    input  logic            f7_bit,
    output logic [SIZE-1:0] result
);

    logic [4:0] w_shamt;
    assign w_shamt = value2[4:0];

    always_comb begin
        result = '0;
        case (func_type)
            3'b000:  result = f7_bit ? (value1 - value2) : (value1 + value2);
            3'b001:  result = value1 << w_shamt;
            3'b010:  result = {{(SIZE-1){1'b0}}, ($signed(value1) < $signed(value2))};
            3'b011:  result = {{(SIZE-1){1'b0}}, (value1 < value2)};
            3'b100:  result = value1 ^ value2;
            3'b101:  result = f7_bit ? $unsigned($signed(value1) >>> w_shamt)
                                     : (value1 >> w_shamt);
            3'b110:  result = value1 | value2;
            default: result = value1 & value2;
        endcase
    end

endmodule

module alu_scheduler #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SIZE-1:0] req0_value1,
    input  logic [SIZE-1:0] req0_value2,
    input  logic [2:0]      req0_func_type,
    input  logic            req0_f7_bit,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [SIZE-1:0] resp0_result,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SIZE-1:0] req1_value1,
    input  logic [SIZE-1:0] req1_value2,
    input  logic [2:0]      req1_func_type,
    input  logic            req1_f7_bit,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [SIZE-1:0] resp1_result,
    output logic            busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_exec = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            r_last_grant;
    logic            r_owner;
    logic [SIZE-1:0] r_value1;
    logic [SIZE-1:0] r_value2;
    logic [2:0]      r_func_type;
    logic            r_f7_bit;
    logic [SIZE-1:0] r_result;
    logic [SIZE-1:0] w_alu_result;

    logic w_grant_valid;
    logic w_grant_port;
    logic w_accept;
    logic w_resp_done;

    // On a tie the port that did not win last time is granted
    assign w_grant_valid = req0_valid | req1_valid;
    assign w_grant_port  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept      = (r_state == c_idle) & w_grant_valid;
    assign w_resp_done   = (r_state == c_resp) & (r_owner ? resp1_ready : resp0_ready);

    alu #(.SIZE(SIZE)) u_alu (
        .value1    (r_value1),
        .value2    (r_value2),
        .func_type (r_func_type),
        .f7_bit    (r_f7_bit),
        .result    (w_alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_state_next = c_exec;
            c_exec:  w_state_next = c_resp;
            c_resp:  if (w_resp_done) w_state_next = c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        resp0_result = '0;
        resp1_result = '0;
        busy         = (r_state != c_idle);
        case (r_state)
            c_idle: begin
                req0_ready = w_grant_valid & ~w_grant_port;
                req1_ready = w_grant_valid &  w_grant_port;
            end
            c_resp: begin
                if (r_owner) begin
                    resp1_valid  = 1'b1;
                    resp1_result = r_result;
                end else begin
                    resp0_valid  = 1'b1;
                    resp0_result = r_result;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_value1     <= '0;
            r_value2     <= '0;
            r_func_type  <= '0;
            r_f7_bit     <= 1'b0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant_port;
                r_last_grant <= w_grant_port;
                r_value1     <= w_grant_port ? req1_value1    : req0_value1;
                r_value2     <= w_grant_port ? req1_value2    : req0_value2;
                r_func_type  <= w_grant_port ? req1_func_type : req0_func_type;
                r_f7_bit     <= w_grant_port ? req1_f7_bit    : req0_f7_bit;
            end
            if (r_state == c_exec) begin
                r_result <= w_alu_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
// ============================================================================
//  Module      : tb_alu_scheduler
//  Description : Directed vector bench for alu_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_scheduler;

    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_ready, req0_f7_bit;
    logic [SIZE-1:0] req0_value1, req0_value2;
    logic [2:0]      req0_func_type;
    logic            resp0_valid, resp0_ready;
    logic [SIZE-1:0] resp0_result;
    logic            req1_valid, req1_ready, req1_f7_bit;
    logic [SIZE-1:0] req1_value1, req1_value2;
    logic [2:0]      req1_func_type;
    logic            resp1_valid, resp1_ready;
    logic [SIZE-1:0] resp1_result;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_scheduler #(.SIZE(SIZE)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_value1    (req0_value1),
        .req0_value2    (req0_value2),
        .req0_func_type (req0_func_type),
        .req0_f7_bit    (req0_f7_bit),
        .resp0_valid    (resp0_valid),
        .resp0_ready    (resp0_ready),
        .resp0_result   (resp0_result),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_value1    (req1_value1),
        .req1_value2    (req1_value2),
        .req1_func_type (req1_func_type),
        .req1_f7_bit    (req1_f7_bit),
        .resp1_valid    (resp1_valid),
        .resp1_ready    (resp1_ready),
        .resp1_result   (resp1_result),
        .busy           (busy)
    );

    typedef struct {
        string       name;
        logic        port;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [2:0]  func;
        logic        f7;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic f7);
        if (p) begin
            req1_valid = v; req1_value1 = a; req1_value2 = b; req1_func_type = f; req1_f7_bit = f7;
        end else begin
            req0_valid = v; req0_value1 = a; req0_value2 = b; req0_func_type = f; req0_f7_bit = f7;
        end
    endtask

    // Single operation on one port; operands are scrambled right after accept
    task automatic run_op(input vec_t v, input int hold);
        @(negedge clk);
        drive(v.port, 1'b1, v.v1, v.v2, v.func, v.f7);
        #1;
        chk({v.name, "/ready"}, {31'd0, v.port ? req1_ready : req0_ready}, 32'd1);
        chk({v.name, "/other_ready"}, {31'd0, v.port ? req0_ready : req1_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(v.port, 1'b0, ~v.v1, ~v.v2, ~v.func, ~v.f7);
        #1;
        chk({v.name, "/exec_busy"}, {31'd0, busy}, 32'd1);
        chk({v.name, "/exec_valid"}, {31'd0, resp0_valid | resp1_valid}, 32'd0);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            #1;
            chk({v.name, "/valid"}, {31'd0, v.port ? resp1_valid : resp0_valid}, 32'd1);
            chk({v.name, "/result"}, v.port ? resp1_result : resp0_result, v.exp);
            chk({v.name, "/other_valid"}, {31'd0, v.port ? resp0_valid : resp1_valid}, 32'd0);
            chk({v.name, "/other_result"}, v.port ? resp0_result : resp1_result, 32'd0);
        end
        if (v.port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        chk({v.name, "/idle_busy"}, {31'd0, busy}, 32'd0);
        chk({v.name, "/idle_valid"}, {31'd0, resp0_valid | resp1_valid}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"add",       1'b0, 32'd5,         32'd3,         3'b000, 1'b0, 32'd8};
        vecs[1]  = '{"sub_wrap",  1'b1, 32'd3,         32'd5,         3'b000, 1'b1, 32'hFFFF_FFFE};
        vecs[2]  = '{"sra",       1'b1, 32'h8000_0000, 32'd4,         3'b101, 1'b1, 32'hF800_0000};
        vecs[3]  = '{"slt",       1'b1, 32'hFFFF_FFFF, 32'd1,         3'b010, 1'b0, 32'd1};
        vecs[4]  = '{"sltu",      1'b1, 32'hFFFF_FFFF, 32'd1,         3'b011, 1'b0, 32'd0};
        vecs[5]  = '{"sll31",     1'b0, 32'd1,         32'd31,        3'b001, 1'b0, 32'h8000_0000};
        vecs[6]  = '{"srl",       1'b0, 32'h8000_0000, 32'd4,         3'b101, 1'b0, 32'h0800_0000};
        vecs[7]  = '{"or",        1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 3'b110, 1'b0, 32'hF0F0_0F0F};
        vecs[8]  = '{"and",       1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b111, 1'b0, 32'h0F00_0F00};
        vecs[9]  = '{"sll_mask",  1'b0, 32'd1,         32'd33,        3'b001, 1'b0, 32'd2};
        vecs[10] = '{"add_wrap",  1'b0, 32'hFFFF_FFFF, 32'd1,         3'b000, 1'b0, 32'd0};
        vecs[11] = '{"xor_p1",    1'b1, 32'h1234_5678, 32'hFFFF_0000, 3'b100, 1'b0, 32'hEDCB_5678};

        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset/busy", {31'd0, busy}, 32'd0);
        chk("reset/resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
        chk("reset/resp0_result", resp0_result, 32'd0);
        chk("reset/resp1_result", resp1_result, 32'd0);
        chk("reset/req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i], (i == 0) ? 2 : 0);

        // Both ports continuously valid: grants must alternate starting with port 0
        do_reset();
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            logic exp_p;
            logic got;
            exp_p = it[0];
            got   = 1'b0;
            drive(1'b0, 1'b1, 32'd100 + it, 32'd0, 3'b000, 1'b0);
            drive(1'b1, 1'b1, 32'd200 + it, 32'd0, 3'b000, 1'b0);
            for (int w = 0; w < 6 && !got; w++) begin
                #1;
                if (req0_ready | req1_ready) got = 1'b1;
                else @(negedge clk);
            end
            chk("rr/grant_seen", {31'd0, got}, 32'd1);
            chk("rr/req1_ready", {31'd0, req1_ready}, {31'd0, exp_p});
            chk("rr/req0_ready", {31'd0, req0_ready}, {31'd0, ~exp_p});
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("rr/own_valid", {31'd0, exp_p ? resp1_valid : resp0_valid}, 32'd1);
            chk("rr/other_valid", {31'd0, exp_p ? resp0_valid : resp1_valid}, 32'd0);
            chk("rr/result", exp_p ? resp1_result : resp0_result, (exp_p ? 32'd200 : 32'd100) + it);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // Backpressure on port 0 while port 1 waits
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b0);
        #1;
        chk("bp/req0_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b1, 32'd5, 32'd6, 3'b000, 1'b0);
        #1;
        chk("bp/exec_req1_ready", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp/resp0_valid", {31'd0, resp0_valid}, 32'd1);
            chk("bp/resp0_result", resp0_result, 32'h0FF0_0FF0);
            chk("bp/req1_ready", {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        resp0_ready = 1'b1;
        #1;
        chk("bp/req1_ready_release", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        chk("bp/req1_accept", {31'd0, req1_ready}, 32'd1);
        chk("bp/idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("bp/resp1_result", resp1_result, 32'd11);
        resp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp1_ready = 1'b0;

        // Reset during EXEC discards the op and restores port-0 tie priority
        drive(1'b0, 1'b1, 32'd7, 32'd7, 3'b000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        #1;
        chk("rst/exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst/busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("rst/no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
            @(negedge clk);
            #1;
        end
        drive(1'b0, 1'b1, 32'd1, 32'd2, 3'b000, 1'b0);
        drive(1'b1, 1'b1, 32'd9, 32'd9, 3'b000, 1'b0);
        #1;
        chk("rst/req0_first", {31'd0, req0_ready}, 32'd1);
        chk("rst/req1_waits", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst/resp0_result", resp0_result, 32'd3);
        resp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp0_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
